// File: rtl/muldiv_pkg.sv
// Shared encodings and default widths for the iterative multiply/divide unit.
package muldiv_pkg;
  localparam int WIDTH_DEF = 32;
  localparam int RD_W_DEF  = 5;

  typedef enum logic [1:0] {
    OP_MUL   = 2'b00,
    OP_MULHU = 2'b01,
    OP_DIVU  = 2'b10,
    OP_REMU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;
endpackage

// File: rtl/muldiv_ctrl.sv
// Sequencer for muldiv_unit: IDLE/RUN/DONE FSM, iteration counter, busy/write
// strobes. With MULDIV_ZERO_SKIP_EN defined, a zero operand ends RUN after
// one cycle; otherwise no zero-detect logic exists.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
`ifdef MULDIV_ZERO_SKIP_EN
  input  op_e  op,
  input  logic a_zero,
  input  logic b_zero,
`endif
  output logic accept,
  output logic fin,
  output logic skip,
  output logic busy,
  output logic write
);
  localparam int CW = $clog2(WIDTH);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic            last;

  assign last = (cnt_q == CW'(WIDTH - 1));

`ifdef MULDIV_ZERO_SKIP_EN
  // Any product with a zero factor, or any divide by zero, has a fixed answer.
  assign skip = (state_q == ST_RUN) &&
                (b_zero || (a_zero && (op == OP_MUL || op == OP_MULHU)));
`else
  assign skip = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Iteration counter: cleared on acceptance, advances once per RUN cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                cnt_q <= '0;
    else if (accept)           cnt_q <= '0;
    else if (state_q == ST_RUN) cnt_q <= cnt_q + 1'b1;
  end

  // Next-state and strobe decode; fin marks the edge that enters DONE.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    fin     = 1'b0;
    busy    = (state_q != ST_IDLE);
    write   = (state_q == ST_DONE);
    case (state_q)
      ST_IDLE: if (start) begin
        accept  = 1'b1;
        state_d = ST_RUN;
      end
      ST_RUN: if (last || skip) begin
        fin     = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end
endmodule

// File: rtl/muldiv_unit.sv
// Iterative 32-bit MUL/MULHU/DIVU/REMU unit feeding a register file write port.
// Shift-add multiply and restoring divide share one {hi,lo} register pair.
// Optional macro: MULDIV_ZERO_SKIP_EN (early finish on zero operands).
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int RD_W  = RD_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] Da,
  input  logic [WIDTH-1:0] Db,
  input  logic [RD_W-1:0]  rd_in,
  output logic             busy,
  output logic [WIDTH-1:0] Dc,
  output logic [RD_W-1:0]  rd,
  output logic             write
);
  op_e              op_q;
  logic [WIDTH-1:0] a_q, b_q, hi_q, lo_q;
  logic [RD_W-1:0]  rd_q;
  logic             accept, fin, skip;

  // hi holds product-high / remainder, lo holds multiplier / dividend->quotient.
  logic [WIDTH:0]   msum, rsh, diff;
  logic [WIDTH-1:0] hi_n, lo_n, result, skip_res;
  logic             borrow;

  muldiv_ctrl #(.WIDTH(WIDTH)) u_ctrl (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
`ifdef MULDIV_ZERO_SKIP_EN
    .op     (op_q),
    .a_zero (a_q == '0),
    .b_zero (b_q == '0),
`endif
    .accept (accept),
    .fin    (fin),
    .skip   (skip),
    .busy   (busy),
    .write  (write)
  );

  assign msum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
  assign rsh    = {hi_q, lo_q[WIDTH-1]};
  assign diff   = rsh - {1'b0, b_q};
  assign borrow = diff[WIDTH];

  // One iteration of whichever algorithm the latched op selects.
  always_comb begin
    if (op_q[1]) begin
      hi_n = borrow ? rsh[WIDTH-1:0] : diff[WIDTH-1:0];
      lo_n = {lo_q[WIDTH-2:0], ~borrow};
    end else begin
      hi_n = msum[WIDTH:1];
      lo_n = {msum[0], lo_q[WIDTH-1:1]};
    end
  end

  // Fixed answers for the early-finish path (never selected when skip is 0).
  always_comb begin
    skip_res = a_q;
    case (op_q)
      OP_MUL, OP_MULHU: skip_res = '0;
      OP_DIVU:          skip_res = '1;
      default:          skip_res = a_q;
    endcase
  end

  // MULHU/REMU take the high half, MUL/DIVU the low half.
  assign result = skip ? skip_res : (op_q[0] ? hi_n : lo_n);

  // Operand latch on acceptance, then one iteration per busy cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q <= OP_MUL;
      a_q  <= '0;
      b_q  <= '0;
      rd_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
    end else if (accept) begin
      op_q <= op_e'(op);
      a_q  <= Da;
      b_q  <= Db;
      rd_q <= rd_in;
      hi_q <= '0;
      lo_q <= op[1] ? Da : Db;
    end else if (busy) begin
      hi_q <= hi_n;
      lo_q <= lo_n;
    end
  end

  // Result registers load on the DONE entry edge and hold until the next one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Dc <= '0;
      rd <= '0;
    end else if (fin) begin
      Dc <= result;
      rd <= rd_q;
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized + directed scoreboard bench for muldiv_unit.
module tb_muldiv_unit;
  localparam int W  = 32;
  localparam int RW = 5;
`ifdef MULDIV_ZERO_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic          clk = 1'b0, reset = 1'b0, start = 1'b0;
  logic [1:0]    op = '0;
  logic [W-1:0]  Da = '0, Db = '0;
  logic [RW-1:0] rd_in = '0;
  logic          busy, write;
  logic [W-1:0]  Dc;
  logic [RW-1:0] rd;

  typedef struct {
    logic [W-1:0]  dc;
    logic [RW-1:0] rd;
    int            cyc;
  } exp_t;

  exp_t sb[$];
  int   total = 0, bad = 0, cyc = 0;

  muldiv_unit #(.WIDTH(W), .RD_W(RW)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .Da(Da), .Db(Db),
    .rd_in(rd_in), .busy(busy), .Dc(Dc), .rd(rd), .write(write)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] ref_res(input logic [1:0] o, input logic [W-1:0] a, b);
    logic [63:0] p;
    p = 64'(a) * 64'(b);
    case (o)
      2'd0:    return p[31:0];
      2'd1:    return p[63:32];
      2'd2:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Edges from acceptance to the edge that raises write.
  function automatic int ref_lat(input logic [1:0] o, input logic [W-1:0] a, b);
    if (SKIP && (b == 0 || (o < 2 && a == 0))) return 1;
    return 32;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  // Issue one op at the first idle negedge; returns cycle index of accepting edge.
  task automatic issue(input logic [1:0] o, input logic [W-1:0] a, b,
                       input logic [RW-1:0] r, input bit push, output int acc);
    int n;
    n = 0;
    @(negedge clk);
    while (busy !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      total++; bad++;
      $display("FAIL idle_timeout: busy still %b after %0d cycles", busy, n);
    end
    op = o; Da = a; Db = b; rd_in = r; start = 1'b1;
    acc = cyc + 1;
    if (push) sb.push_back('{ref_res(o, a, b), r, acc + ref_lat(o, a, b)});
    @(negedge clk);
    start = 1'b0;
    op = 2'($urandom); Da = $urandom; Db = $urandom; rd_in = RW'($urandom);
  endtask

  // Monitor: every write must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (reset && write) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL spurious_write: got Dc=%h rd=%0d, expected no write", Dc, rd);
      end else begin
        e = sb.pop_front();
        chk("dc",      64'(Dc),  64'(e.dc));
        chk("rd",      64'(rd),  64'(e.rd));
        chk("latency", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  initial begin
    int acc, nb, n;
    logic [1:0]   ro;
    logic [W-1:0] ra, rb;

    // Held in reset with active-looking inputs.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_busy",  64'(busy),  64'(0));
      chk("rst_write", 64'(write), 64'(0));
      chk("rst_dc",    64'(Dc),    64'(0));
      chk("rst_rd",    64'(rd),    64'(0));
      start = 1'b1; op = 2'($urandom); Da = $urandom; Db = $urandom; rd_in = RW'($urandom);
    end
    @(negedge clk);
    start = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_busy",  64'(busy),  64'(0));
    chk("idle_write", 64'(write), 64'(0));

    // MUL 7*6 with busy-length check.
    issue(2'd0, 32'd7, 32'd6, 5'd3, 1'b1, acc);
    nb = 0;
    while (busy && nb < 100) begin
      nb++;
      @(negedge clk);
    end
    chk("busy_cycles", 64'(nb), 64'(33));

    issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1,  1'b1, acc);
    issue(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  1'b1, acc);
    issue(2'd2, 32'd100,       32'd7,         5'd4,  1'b1, acc);
    issue(2'd3, 32'd100,       32'd7,         5'd5,  1'b1, acc);
    issue(2'd2, 32'h8000_0000, 32'd1,         5'd6,  1'b1, acc);
    issue(2'd2, 32'd123,       32'd0,         5'd7,  1'b1, acc);
    issue(2'd3, 32'd123,       32'd0,         5'd8,  1'b1, acc);
    issue(2'd0, 32'd0,         32'd55,        5'd0,  1'b1, acc);
    issue(2'd3, 32'd5,         32'd9,         5'd31, 1'b1, acc);

    // A start while busy is ignored.
    issue(2'd0, 32'd9, 32'd9, 5'd4, 1'b1, acc);
    repeat (3) @(negedge clk);
    start = 1'b1; op = 2'd2; Da = 32'd1; Db = 32'd1; rd_in = 5'd7;
    @(negedge clk);
    start = 1'b0;

    // Reset mid-operation abandons it.
    issue(2'd2, $urandom | 32'h1, $urandom | 32'h1, 5'd9, 1'b0, acc);
    repeat (8) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort_busy",  64'(busy),  64'(0));
    chk("abort_write", 64'(write), 64'(0));
    chk("abort_dc",    64'(Dc),    64'(0));
    chk("abort_rd",    64'(rd),    64'(0));
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    issue(2'd0, 32'd3, 32'd5, 5'd5, 1'b1, acc);

    // Random ops, with zero and small operands mixed in.
    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 4))
        0:       ra = '0;
        1:       ra = W'($urandom_range(0, 300));
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 4))
        0:       rb = '0;
        1:       rb = W'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      issue(ro, ra, rb, RW'($urandom), 1'b1, acc);
    end

    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      total++; bad++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
